// File: rtl/sync_arith_arbiter_29.sv
// Round-robin front end that shares one sync_arith_unit_29 among N_REQ clients.
// One operation in flight at a time: capture, wait LAT edges, then return the result.
module sync_arith_arbiter_29 #(
    parameter int M     = 32,
    parameter int N_REQ = 4,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*M-1:0] iarg_A,
    input  logic [N_REQ*M-1:0] iarg_B,
    input  logic [N_REQ*4-1:0] iop,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_valid,
    output logic [M-1:0]       o_result,
    output logic [3:0]         o_status,
    output logic               o_busy,
    output logic [M-1:0]       o_unit_A,
    output logic [M-1:0]       o_unit_B,
    output logic [3:0]         o_unit_op,
    input  logic [M-1:0]       i_unit_result,
    input  logic [3:0]         i_unit_status
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt;
    logic [3:0]       cnt;
    logic [PW-1:0]    win;
    logic [PW-1:0]    nxt;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] gnt_oh;

    // First requester at or above the pointer, wrapping around.
    function automatic logic [PW-1:0] pick(input logic [N_REQ-1:0] req,
                                           input logic [PW-1:0]    p);
        logic [PW-1:0] w;
        logic          f;
        int            j;
        w = p;
        f = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(p) + i) % N_REQ;
            if (!f && req[j]) begin
                f = 1'b1;
                w = PW'(j);
            end
        end
        return w;
    endfunction

    assign win    = pick(i_req, ptr);
    assign nxt    = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);
    assign win_oh = N_REQ'(1) << win;
    assign gnt_oh = N_REQ'(1) << gnt;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            o_ack     <= '0;
            o_valid   <= '0;
            o_busy    <= 1'b0;
            o_result  <= '0;
            o_status  <= '0;
            o_unit_A  <= '0;
            o_unit_B  <= '0;
            o_unit_op <= '0;
        end else begin
            o_ack   <= '0;
            o_valid <= '0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        o_unit_A  <= iarg_A[int'(win)*M +: M];
                        o_unit_B  <= iarg_B[int'(win)*M +: M];
                        o_unit_op <= iop[int'(win)*4 +: 4];
                        gnt       <= win;
                        cnt       <= 4'(LAT);
                        ptr       <= nxt;
                        o_ack     <= win_oh;
                        o_busy    <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        o_result <= i_unit_result;
                        o_status <= i_unit_status;
                        o_valid  <= gnt_oh;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
